// File: rtl/ultrasonido_if.sv
// Sensor-ranger handshake bundle: game-side start/result signals plus the two sensor pins.
// The controller takes the slave view; the game logic / sensor model takes the master view.
interface ultrasonido_if #(
    parameter int DW = 9
);
    logic          start;
    logic          echo;
    logic          trigger;
    logic          busy;
    logic          done;
    logic          valid;
    logic          timeout;
    logic [DW-1:0] distance;

    modport master (
        output start, echo,
        input  trigger, busy, done, valid, timeout, distance
    );

    modport slave (
        input  start, echo,
        output trigger, busy, done, valid, timeout, distance
    );
endinterface

// File: rtl/ultrasonido_ctrl.sv
// HC-SR04-class ranger sequencer: trigger pulse, echo timing in cm, timeout and holdoff.
// Define ULTRASONIDO_AUTO_TRIG_EN for free-running back-to-back measurements (start ignored).
module ultrasonido_ctrl #(
    parameter int CLK_PER_US = 100,
    parameter int TRIG_US    = 10,
    parameter int CM_US      = 58,
    parameter int TIMEOUT_US = 30000,
    parameter int HOLDOFF_US = 60000,
    parameter int DW         = 9
) (
    input  logic         clk,
    input  logic         rst,
    ultrasonido_if.slave bus
);
    localparam int US_MAX = (TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US;
    localparam int UW     = $clog2(US_MAX + 1);
    localparam int PW     = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int SW     = (CM_US > 1) ? $clog2(CM_US) : 1;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [UW-1:0] us_q, us_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [DW-1:0] cm_q, cm_d;
    logic          sync1_q, sync2_q;
    logic          trigger_q, trigger_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic [DW-1:0] distance_q, distance_d;

    logic          us_tick;
    logic [UW-1:0] us_inc;
    logic          echo_s;
    logic          go;

    assign echo_s = sync2_q;

`ifdef ULTRASONIDO_AUTO_TRIG_EN
    logic unused_start;
    assign unused_start = bus.start;
    assign go           = 1'b1;
`else
    assign go = bus.start;
`endif

    always_comb begin
        us_tick = (pre_q == PW'(CLK_PER_US - 1));
        us_inc  = us_q + UW'(1);

        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        pre_d      = us_tick ? '0 : pre_q + PW'(1);
        us_d       = us_tick ? us_inc : us_q;
        sub_d      = sub_q;
        cm_d       = cm_q;
        trigger_d  = trigger_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        timeout_d  = timeout_q;
        distance_d = distance_q;

        case (state_q)
            IDLE: begin
                us_d = '0;
                if (go) begin
                    state_d   = TRIG;
                    trigger_d = 1'b1;
                end
            end

            TRIG: begin
                if (us_tick && us_inc == UW'(TRIG_US)) begin
                    state_d   = WAIT_RISE;
                    trigger_d = 1'b0;
                end
            end

            WAIT_RISE: begin
                if (echo_s) begin
                    state_d = MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (us_tick && us_inc == UW'(TIMEOUT_US)) begin
                    state_d    = HOLDOFF;
                    done_d     = 1'b1;
                    valid_d    = 1'b0;
                    timeout_d  = 1'b1;
                    distance_d = '1;
                end
            end

            MEASURE: begin
                if (us_tick) begin
                    if (sub_q == SW'(CM_US - 1)) begin
                        sub_d = '0;
                        if (cm_q != {DW{1'b1}}) cm_d = cm_q + DW'(1);
                    end else begin
                        sub_d = sub_q + SW'(1);
                    end
                end
                // Falling echo outranks a coincident timeout; the tick of this cycle still counts.
                if (!echo_s) begin
                    state_d    = HOLDOFF;
                    done_d     = 1'b1;
                    valid_d    = 1'b1;
                    timeout_d  = 1'b0;
                    distance_d = cm_d;
                end else if (us_tick && us_inc == UW'(TIMEOUT_US)) begin
                    state_d    = HOLDOFF;
                    done_d     = 1'b1;
                    valid_d    = 1'b0;
                    timeout_d  = 1'b1;
                    distance_d = '1;
                end
            end

            HOLDOFF: begin
                if (us_tick && us_inc == UW'(HOLDOFF_US)) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Timebase restarts on every state entry so each interval is measured from its own start.
        if (state_d != state_q) begin
            pre_d = '0;
            us_d  = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            us_q       <= '0;
            sub_q      <= '0;
            cm_q       <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            distance_q <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            us_q       <= us_d;
            sub_q      <= sub_d;
            cm_q       <= cm_d;
            sync1_q    <= bus.echo;
            sync2_q    <= sync1_q;
            trigger_q  <= trigger_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            distance_q <= distance_d;
        end
    end

    assign bus.trigger  = trigger_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.valid    = valid_q;
    assign bus.timeout  = timeout_q;
    assign bus.distance = distance_q;
endmodule
